// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory-port arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_t;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  localparam int BYTES_PER_WORD = 4;

  // Byte 0 is the least significant byte of the word.
  typedef logic [BYTES_PER_WORD-1:0][7:0] word_t;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// rtl/mem_arbiter_rr_arb2.sv - two-way round-robin picker owning the last-grant register
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_b,
  input  logic [1:0] req,
  input  logic       update,
  output logic       grant
);

  logic last_grant_q;

  // A single requester always wins; a tie goes to the side not served last.
  always_comb begin
    grant = ~last_grant_q;
    unique case (req)
      2'b01:   grant = GNT_I;
      2'b10:   grant = GNT_D;
      default: grant = ~last_grant_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      last_grant_q <= GNT_I;
    end else if (update) begin
      last_grant_q <= grant;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one memory port between the I-cache and D-cache
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY = 2,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output word_t             i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_write_en,
  input  logic [ADDR_W-1:0] d_addr,
  input  word_t             d_wdata,
  output word_t             d_rdata,
  output logic              d_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write_en,
  output word_t             mem_data_in,
  input  word_t             mem_data_out,
  output logic              busy
);

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);

  arb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              gnt_q, gnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  word_t             mem_din_q, mem_din_d;
  word_t             i_rdata_q, i_rdata_d;
  word_t             d_rdata_q, d_rdata_d;
  logic              pick;
  logic              pick_update;

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .rst_b  (rst_b),
    .req    ({d_req, i_req}),
    .update (pick_update),
    .grant  (pick)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_din_d   = mem_din_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    pick_update = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          pick_update = 1'b1;
          state_d     = ACCESS;
          cnt_d       = '0;
          gnt_d       = pick;
          if (pick == GNT_D) begin
            mem_addr_d = d_addr;
            mem_we_d   = d_write_en;
            mem_din_d  = d_wdata;
          end else begin
            mem_addr_d = i_addr;
            mem_we_d   = 1'b0;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == CNT_W'(MEM_LATENCY - 1)) begin
          state_d  = RESP;
          cnt_d    = '0;
          mem_we_d = 1'b0;
          // Writes leave both read-data registers untouched.
          if (!mem_we_q) begin
            if (gnt_q == GNT_D) d_rdata_d = mem_data_out;
            else                i_rdata_d = mem_data_out;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      gnt_q      <= GNT_I;
      mem_addr_q <= '0;
      mem_we_q   <= 1'b0;
      mem_din_q  <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      mem_addr_q <= mem_addr_d;
      mem_we_q   <= mem_we_d;
      mem_din_q  <= mem_din_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign i_ack        = (state_q == RESP) && (gnt_q == GNT_I);
  assign d_ack        = (state_q == RESP) && (gnt_q == GNT_D);
  assign mem_addr     = mem_addr_q;
  assign mem_write_en = mem_we_q;
  assign mem_data_in  = mem_din_q;
  assign i_rdata      = i_rdata_q;
  assign d_rdata      = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed scoreboard bench for mem_arbiter
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_b;
  logic        i_req, d_req, d_write_en;
  logic [31:0] i_addr, d_addr, mem_addr;
  word_t       i_rdata, d_rdata, d_wdata, mem_data_in, mem_data_out;
  logic        i_ack, d_ack, mem_write_en, busy;

  logic        s1_i_req, s1_d_req, s1_d_write_en;
  logic [31:0] s1_i_addr, s1_d_addr, s1_mem_addr;
  word_t       s1_i_rdata, s1_d_rdata, s1_d_wdata, s1_mem_data_in, s1_mem_data_out;
  logic        s1_i_ack, s1_d_ack, s1_mem_write_en, s1_busy;

  mem_arbiter #(.MEM_LATENCY(2), .ADDR_W(32)) dut (
    .clk(clk), .rst_b(rst_b),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_write_en(d_write_en), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_addr(mem_addr), .mem_write_en(mem_write_en), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .busy(busy)
  );

  mem_arbiter #(.MEM_LATENCY(1), .ADDR_W(32)) dut_lat1 (
    .clk(clk), .rst_b(rst_b),
    .i_req(s1_i_req), .i_addr(s1_i_addr), .i_rdata(s1_i_rdata), .i_ack(s1_i_ack),
    .d_req(s1_d_req), .d_write_en(s1_d_write_en), .d_addr(s1_d_addr), .d_wdata(s1_d_wdata),
    .d_rdata(s1_d_rdata), .d_ack(s1_d_ack),
    .mem_addr(s1_mem_addr), .mem_write_en(s1_mem_write_en), .mem_data_in(s1_mem_data_in),
    .mem_data_out(s1_mem_data_out), .busy(s1_busy)
  );

  typedef struct {
    logic        side;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic side, input logic [31:0] data);
    exp_t e;
    e.side = side;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every ack is matched against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_b) begin
      check("ack_exclusive", 32'(i_ack & d_ack), 32'd0);
      if (i_ack || d_ack) begin
        check("ack_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check("ack_side", 32'(d_ack), 32'(mon_e.side));
          check("ack_rdata", d_ack ? d_rdata : i_rdata, mon_e.data);
        end
      end
    end
  end

  initial begin
    rst_b = 1'b0;
    i_req = 0; d_req = 0; d_write_en = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0; mem_data_out = 0;
    s1_i_req = 0; s1_d_req = 0; s1_d_write_en = 0;
    s1_i_addr = 0; s1_d_addr = 0; s1_d_wdata = 0; s1_mem_data_out = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_i_ack", 32'(i_ack), 0);
    check("rst_d_ack", 32'(d_ack), 0);
    check("rst_mem_we", 32'(mem_write_en), 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_din", mem_data_in, 0);
    check("rst_i_rdata", i_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_s1_busy", 32'(s1_busy), 0);
    rst_b = 1'b1;

    // D read alone
    tick();
    d_req = 1; d_write_en = 0; d_addr = 32'h100; mem_data_out = 32'hDEADBEEF;
    push(GNT_D, 32'hDEADBEEF);
    check("rd_c0_busy", 32'(busy), 0);
    tick();
    check("rd_c1_addr", mem_addr, 32'h100);
    check("rd_c1_busy", 32'(busy), 1);
    check("rd_c1_we", 32'(mem_write_en), 0);
    check("rd_c1_ack", 32'(d_ack), 0);
    tick();
    check("rd_c2_addr", mem_addr, 32'h100);
    check("rd_c2_ack", 32'(d_ack), 0);
    tick();
    check("rd_c3_ack", 32'(d_ack), 1);
    check("rd_c3_iack", 32'(i_ack), 0);
    check("rd_c3_rdata", d_rdata, 32'hDEADBEEF);
    d_req = 0;
    tick();
    check("rd_c4_busy", 32'(busy), 0);
    check("rd_c4_ack", 32'(d_ack), 0);

    // D write
    d_req = 1; d_write_en = 1; d_addr = 32'h40; d_wdata = 32'h12345678;
    mem_data_out = 32'hCAFEF00D;
    push(GNT_D, 32'hDEADBEEF);
    check("wr_c0_we", 32'(mem_write_en), 0);
    tick();
    check("wr_c1_we", 32'(mem_write_en), 1);
    check("wr_c1_din", mem_data_in, 32'h12345678);
    check("wr_c1_addr", mem_addr, 32'h40);
    tick();
    check("wr_c2_we", 32'(mem_write_en), 1);
    check("wr_c2_din", mem_data_in, 32'h12345678);
    tick();
    check("wr_c3_ack", 32'(d_ack), 1);
    check("wr_c3_we", 32'(mem_write_en), 0);
    check("wr_c3_rdata", d_rdata, 32'hDEADBEEF);
    d_req = 0; d_write_en = 0;
    tick();
    check("wr_c4_din_held", mem_data_in, 32'h12345678);
    check("wr_c4_we", 32'(mem_write_en), 0);

    // Tie after reset: D first, then I, then D again
    rst_b = 0;
    tick();
    rst_b = 1;
    tick();
    i_req = 1; d_req = 1; i_addr = 32'h0; d_addr = 32'h8;
    mem_data_out = 32'h11112222;
    push(GNT_D, 32'h11112222);
    tick();
    check("tie_c1_addr", mem_addr, 32'h8);
    tick();
    tick();
    check("tie_c3_dack", 32'(d_ack), 1);
    check("tie_c3_iack", 32'(i_ack), 0);
    mem_data_out = 32'h33334444;
    push(GNT_I, 32'h33334444);
    tick();
    check("tie_c4_busy", 32'(busy), 0);
    tick();
    check("tie_c5_addr", mem_addr, 32'h0);
    check("tie_c5_we", 32'(mem_write_en), 0);
    tick();
    tick();
    check("tie_c7_iack", 32'(i_ack), 1);
    check("tie_c7_irdata", i_rdata, 32'h33334444);
    check("tie_c7_drdata", d_rdata, 32'h11112222);
    mem_data_out = 32'h55556666;
    push(GNT_D, 32'h55556666);
    tick();
    tick();
    check("tie_c9_addr", mem_addr, 32'h8);
    i_req = 0; d_req = 0;
    tick();
    tick();
    check("tie_c11_dack", 32'(d_ack), 1);
    check("tie_c11_irdata", i_rdata, 32'h33334444);
    tick();

    // Back-to-back I with req held
    for (int c = 0; c <= 12; c++) begin
      if (c == 0) begin
        i_req = 1; i_addr = 32'h200;
      end
      if (c % 4 == 0 && c < 12) push(GNT_I, 32'hA000_0000 | 32'(c / 4));
      if (c % 4 == 1) begin
        mem_data_out = 32'hA000_0000 | 32'(c / 4);
        check("b2b_addr", mem_addr, 32'h200);
      end
      check("b2b_busy", 32'(busy), 32'(c % 4 != 0));
      check("b2b_iack", 32'(i_ack), 32'(c % 4 == 3));
      if (c == 11) i_req = 0;
      if (c < 12) tick();
    end

    // Reset in the middle of a D write
    d_req = 1; d_write_en = 1; d_addr = 32'h80; d_wdata = 32'h55AA55AA;
    tick();
    check("rw_c1_we", 32'(mem_write_en), 1);
    d_req = 0; d_write_en = 0;
    tick();
    rst_b = 0;
    #1;
    check("rw_we_drop", 32'(mem_write_en), 0);
    check("rw_busy", 32'(busy), 0);
    check("rw_addr", mem_addr, 0);
    check("rw_din", mem_data_in, 0);
    tick();
    rst_b = 1;
    tick();
    tick();
    check("rw_no_dack", 32'(d_ack), 0);
    check("rw_idle", 32'(busy), 0);
    i_req = 1; i_addr = 32'h44; mem_data_out = 32'h77778888;
    push(GNT_I, 32'h77778888);
    tick();
    check("rw_regrant_busy", 32'(busy), 1);
    check("rw_regrant_addr", mem_addr, 32'h44);
    tick();
    tick();
    check("rw_iack", 32'(i_ack), 1);
    i_req = 0;
    tick();

    // MEM_LATENCY = 1 build
    s1_d_req = 1; s1_d_addr = 32'h300; s1_mem_data_out = 32'h0BADF00D;
    check("l1_c0_busy", 32'(s1_busy), 0);
    tick();
    check("l1_c1_addr", s1_mem_addr, 32'h300);
    check("l1_c1_busy", 32'(s1_busy), 1);
    check("l1_c1_ack", 32'(s1_d_ack), 0);
    tick();
    check("l1_c2_ack", 32'(s1_d_ack), 1);
    check("l1_c2_iack", 32'(s1_i_ack), 0);
    check("l1_c2_rdata", s1_d_rdata, 32'h0BADF00D);
    s1_d_req = 0;
    tick();
    check("l1_c3_busy", 32'(s1_busy), 0);
    check("l1_c3_ack", 32'(s1_d_ack), 0);

    tick();
    check("sb_drained", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single main-memory port between the instruction cache (read-only) and the data cache (read/write).
- Each requester uses a req/ack handshake. The arbiter grants one transaction at a time and drives the memory port for a fixed memory latency.
- It returns a 4-byte word and a one-cycle ack to the granted side.
- Ties are broken round-robin.

Parameters:
- MEM_LATENCY, 2, cycles the memory needs with address/write_en held stable before mem_data_out is valid or a write is committed; legal range ≥1.
- ADDR_W, 32, address width.

Ports:
- clk  input  1  clock, rising edge.
- rst_b  input  1  reset; asynchronous, active-low.
- i_req  input  1  instruction-side request; held until i_ack.
- i_addr  input  ADDR_W  instruction-side word address.
- i_rdata  output  [7:0] x [0:3]  instruction read data; byte 0 is the LSB.
- i_ack  output  1  one-cycle completion pulse for the instruction side.
- d_req  input  1  data-side request; held until d_ack.
- d_write_en  input  1  1 = write, 0 = read.
- d_addr  input  ADDR_W  data-side word address.
- d_wdata  input  [7:0] x [0:3]  data-side write data.
- d_rdata  output  [7:0] x [0:3]  data-side read data.
- d_ack  output  1  one-cycle completion pulse for the data side.
- mem_addr  output  ADDR_W  memory address.
- mem_write_en  output  1  memory write strobe.
- mem_data_in  output  [7:0] x [0:3]  memory write data.
- mem_data_out  input  [7:0] x [0:3]  memory read data.
- busy  output  1  high in ACCESS and RESP.

Behaviour:
- States:
  - IDLE → ACCESS when any req is sampled high.
  - ACCESS → RESP when cnt == MEM_LATENCY-1.
  - RESP → IDLE unconditionally.
- Arbitration (IDLE only):
  - If only one req is high, that side wins.
  - If both are high, the side not granted last wins. last_grant resets to I, so the first tie goes to D.
  - last_grant updates on every grant.
- On grant (IDLE edge): latch address, write_en and wdata of the winner into mem_addr, mem_write_en and mem_data_in. Instruction grants force mem_write_en = 0. cnt clears to 0.
- ACCESS:
  - mem_addr, mem_write_en and mem_data_in are held stable.
  - cnt increments each cycle.
  - On the last ACCESS edge, for a read only, mem_data_out is captured into the granted side's rdata register. The other side's rdata register is unchanged.
- RESP:
  - The granted side's ack is high for exactly one cycle; its rdata is valid that cycle and held thereafter until the next read on that side.
  - mem_write_en is 0.
  - For writes, rdata is unchanged.
- Latency: req sampled at edge of cycle 0 → ACCESS for cycles 1..MEM_LATENCY → ack in cycle MEM_LATENCY+1 → IDLE in cycle MEM_LATENCY+2.
- Throughput: one transaction per MEM_LATENCY+2 cycles.
- Handshake:
  - Exactly one ack per grant; i_ack and d_ack are never high together.
  - A req still high in the cycle after its ack is a new transaction.
  - Req inputs are ignored outside IDLE.
  - The loser of a tie keeps req high and is granted in the next IDLE.
- mem_write_en is 0 in IDLE and RESP. mem_addr and mem_data_in hold their last values outside ACCESS.
- Reset values (asynchronous, also mid-transaction): state IDLE, cnt 0, last_grant I, all acks 0, busy 0, mem_write_en 0, mem_addr 0, mem_data_in all bytes 0, i_rdata/d_rdata all bytes 0. An aborted transaction produces no ack.
- cnt width: $clog2(MEM_LATENCY+1). cnt never exceeds MEM_LATENCY-1.

Decomposition:
- Package mem_arb_pkg:
  - typedef enum arb_state_t {IDLE, ACCESS, RESP}.
  - Constants GNT_I = 1'b0 and GNT_D = 1'b1.
  - Localparam BYTES_PER_WORD = 4.
- Sub-module rr_arb2: two-way round-robin picker.
  - Inputs: req[1:0], update.
  - Output: grant.
  - Owns the last_grant register, reset to GNT_I.

Test Plan:
- D read alone (MEM_LATENCY=2): d_req=1, d_addr=0x100, mem_data_out=0xDEADBEEF from cycle 1 → mem_addr=0x100 in cycles 1–2, d_ack high only in cycle 3, d_rdata=0xDEADBEEF, i_ack never asserted.
- D write: d_write_en=1, d_addr=0x40, d_wdata=0x12345678 → mem_write_en=1 exactly in cycles 1–2 with mem_data_in=0x12345678, d_ack in cycle 3, d_rdata unchanged.
- Tie after reset: i_req=d_req=1 held, i_addr=0x0, d_addr=0x8 → D granted first (d_ack in cycle 3); I granted at cycle 4 (i_ack in cycle 7). With both still held, the next grant is D.
- Back-to-back I: i_req held high continuously → i_ack pulses at cycles 3, 7, 11. busy low only in cycles 0, 4, 8.
- Reset mid-write: assert rst_b=0 in cycle 2 of a D write → mem_write_en drops immediately, no d_ack. After release, an idle-state grant occurs on the next sampled req.
- MEM_LATENCY=1 build: d read → mem_addr valid cycle 1 only, d_ack in cycle 2.
